vote_tally_engine: RTL and testbench
====================================

VOTE_TALLY_ENGINE -- requirements
Module: vote_tally_engine

Interface
REQ-001 SHALL have parameter NUM_CAND, default 4, number of candidates (2..16).
REQ-002 SHALL have parameter CNT_W, default 8, per-candidate counter width.
REQ-003 SHALL have parameter VID_W, default 4, voter-ID width; the electorate is 2^VID_W voters.
REQ-004 SHALL have parameter TOT_W, default 12, total-vote counter width.
REQ-005 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port cmd_valid  in  1  command strobe, sampled each cycle.
REQ-008 SHALL have port cmd  in  2  command: 01 OPEN, 10 CLOSE, 11 CLEAR, 00 none.
REQ-009 SHALL have port vote_valid  in  1  ballot present.
REQ-010 SHALL have port vote_ready  out  1  high exactly when state is VOTING.
REQ-011 SHALL have port cand_sel  in  NUM_CAND  one-hot candidate choice.
REQ-012 SHALL have port voter_id  in  VID_W  voter identity.
REQ-013 SHALL have port vote_ack  out  1  one-cycle pulse: ballot counted.
REQ-014 SHALL have port vote_rej  out  1  one-cycle pulse: ballot refused.
REQ-015 SHALL have port rej_code  out  2  reason: 01 not one-hot, 10 duplicate voter, 11 saturated; 00 otherwise.
REQ-016 SHALL have port state  out  2  00 IDLE, 01 VOTING, 10 TALLY, 11 RESULT.
REQ-017 SHALL have port winner  out  NUM_CAND  one-hot winner, valid in RESULT, else 0.
REQ-018 SHALL have port tie  out  1  maximum count shared by two or more candidates, valid in RESULT, else 0.
REQ-019 SHALL have port total  out  TOT_W  accepted ballots so far.
REQ-020 SHALL have port rd_idx  in  4  candidate index for count readback.
REQ-021 SHALL have port rd_count  out  CNT_W  count of candidate rd_idx, registered, 1-cycle latency; 0 if rd_idx >= NUM_CAND.

Function
REQ-022 SHALL implement the FSM as: IDLE -OPEN-> VOTING -CLOSE-> TALLY -(NUM_CAND cycles)-> RESULT -OPEN-> VOTING (counts retained, voting resumes).
REQ-023 SHALL apply CLEAR in any state as follows: next cycle IDLE; all counts, total, voted bitmap, winner and tie = 0.
REQ-024 SHALL ignore commands not listed for the current state, with no side effects.
REQ-025 SHALL handshake ballots as follows: transfer when vote_valid && vote_ready; ack or rej asserted on the following cycle, for exactly one cycle; never both.
REQ-026 SHALL check ballots in priority order: not one-hot (including all-zero) -> 01; voter_id bit set in the voted bitmap -> 10; selected count at 2^CNT_W-1 or total at 2^TOT_W-1 -> 11; else accept.
REQ-027 SHALL, on accept at the same edge: increment selected count by 1, increment total by 1, set voted bit.
REQ-028 SHALL leave counts, total and bitmap unchanged on reject.
REQ-029 SHALL give CLEAR priority over a ballot transferred in the same cycle: ballot discarded, no ack, no rej.
REQ-030 SHALL accept and count a ballot transferred in the same cycle as CLOSE, then enter TALLY.
REQ-031 SHALL perform TALLY as a sequential scan of one candidate per cycle, index 0..NUM_CAND-1, tracking max, winner index and tie flag; a strictly greater count replaces winner and clears tie; an equal nonzero count sets tie.
REQ-032 SHALL resolve a tie to the lowest-index candidate holding the maximum.
REQ-033 SHALL, when all counts are 0, give winner = 0 and tie = 0 in RESULT.
REQ-034 SHALL drive winner and tie to 0 in every state except RESULT.
REQ-035 SHALL keep counters in VOTING from wrapping (saturation reject per REQ-026).

Reset
REQ-036 SHALL on rst: state IDLE; counts, total, bitmap, winner, tie, vote_ack, vote_rej, rej_code and rd_count all 0, immediately and asynchronously.
REQ-037 SHALL on rst mid-TALLY or mid-handshake: abort the operation, produce no ack/rej pulse after release, and leave the FSM in IDLE.

Verification
REQ-038 SHALL cover: OPEN; ballots (id1,c0), (id2,c2), (id3,c2); CLOSE -> 3 acks, total=3, RESULT after 4 TALLY cycles, winner=0100, tie=0.
REQ-039 SHALL cover: ballot id1 twice, then cand_sel=0011 -> second gets rej_code 10, third gets 01; total=1.
REQ-040 SHALL cover: id0->c1, id1->c3; CLOSE -> winner=0010, tie=1; all-zero session -> winner=0000, tie=0.
REQ-041 SHALL cover: CNT_W=2, four ballots to c0 by distinct ids -> acks for first 3, rej_code 11 on 4th, count stays 3.
REQ-042 SHALL cover: CLEAR coincident with a valid ballot -> no ack/rej, IDLE, total=0; rst asserted mid-TALLY -> IDLE, outputs 0.
REQ-043 SHALL cover: in RESULT, rd_idx=2 -> rd_count equals c2 count one cycle later; rd_idx=9 -> 0.

Source files
------------

// File: rtl/vote_tally_engine.sv
// Ballot-counting engine: accepts one-hot ballots while VOTING, refuses duplicate voters
// and saturated counters, then scans the per-candidate counts for a winner.
module vote_tally_engine #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int VID_W    = 4,
  parameter int TOT_W    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd,
  input  logic                vote_valid,
  output logic                vote_ready,
  input  logic [NUM_CAND-1:0] cand_sel,
  input  logic [VID_W-1:0]    voter_id,
  output logic                vote_ack,
  output logic                vote_rej,
  output logic [1:0]          rej_code,
  output logic [1:0]          state,
  output logic [NUM_CAND-1:0] winner,
  output logic                tie,
  output logic [TOT_W-1:0]    total,
  input  logic [3:0]          rd_idx,
  output logic [CNT_W-1:0]    rd_count
);

  localparam int IDX_W      = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int NUM_VOTERS = 2 ** VID_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_VOTING = 2'b01,
    S_TALLY  = 2'b10,
    S_RESULT = 2'b11
  } state_e;

  localparam logic [1:0] CMD_OPEN  = 2'b01;
  localparam logic [1:0] CMD_CLOSE = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  localparam logic [1:0] REJ_ONEHOT = 2'b01;
  localparam logic [1:0] REJ_DUP    = 2'b10;
  localparam logic [1:0] REJ_SAT    = 2'b11;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q [NUM_CAND];
  logic [CNT_W-1:0]      cnt_d [NUM_CAND];
  logic [TOT_W-1:0]      total_q, total_d;
  logic [NUM_VOTERS-1:0] voted_q, voted_d;
  logic                  ack_q, ack_d, rej_q, rej_d;
  logic [1:0]            code_q, code_d;
  logic [IDX_W-1:0]      scan_q, scan_d, widx_q, widx_d;
  logic [CNT_W-1:0]      max_q, max_d;
  logic                  tie_q, tie_d;
  logic [CNT_W-1:0]      rd_q, rd_d;

  logic                  clear, transfer, one_hot, dup, sat;
  logic [IDX_W-1:0]      sel_idx;
  logic [CNT_W-1:0]      sel_cnt, scan_cnt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    total_d  = total_q;
    voted_d  = voted_q;
    ack_d    = 1'b0;
    rej_d    = 1'b0;
    code_d   = 2'b00;
    scan_d   = scan_q;
    widx_d   = widx_q;
    max_d    = max_q;
    tie_d    = tie_q;
    rd_d     = '0;
    sel_idx  = '0;
    sel_cnt  = '0;
    scan_cnt = '0;

    for (int i = 0; i < NUM_CAND; i++) begin
      if (cand_sel[i]) begin
        sel_idx = IDX_W'(i);
        sel_cnt = cnt_q[i];
      end
      if (scan_q == IDX_W'(i)) scan_cnt = cnt_q[i];
      if (rd_idx == 4'(i)) rd_d = cnt_q[i];
    end

    clear    = cmd_valid && (cmd == CMD_CLEAR);
    transfer = vote_valid && (state_q == S_VOTING);
    one_hot  = (cand_sel != '0) && ((cand_sel & (cand_sel - NUM_CAND'(1))) == '0);
    dup      = voted_q[voter_id];
    sat      = (sel_cnt == '1) || (total_q == '1);

    if (clear) begin
      // A ballot transferred alongside CLEAR is dropped without any response.
      state_d = S_IDLE;
      for (int i = 0; i < NUM_CAND; i++) cnt_d[i] = '0;
      total_d = '0;
      voted_d = '0;
      scan_d  = '0;
      widx_d  = '0;
      max_d   = '0;
      tie_d   = 1'b0;
    end else begin
      if (transfer) begin
        if (!one_hot) begin
          rej_d  = 1'b1;
          code_d = REJ_ONEHOT;
        end else if (dup) begin
          rej_d  = 1'b1;
          code_d = REJ_DUP;
        end else if (sat) begin
          rej_d  = 1'b1;
          code_d = REJ_SAT;
        end else begin
          ack_d            = 1'b1;
          cnt_d[sel_idx]   = sel_cnt + CNT_W'(1);
          total_d          = total_q + TOT_W'(1);
          voted_d[voter_id] = 1'b1;
        end
      end

      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd == CMD_OPEN) state_d = S_VOTING;
        end
        S_VOTING: begin
          if (cmd_valid && cmd == CMD_CLOSE) begin
            state_d = S_TALLY;
            scan_d  = '0;
            widx_d  = '0;
            max_d   = '0;
            tie_d   = 1'b0;
          end
        end
        S_TALLY: begin
          // Strictly greater wins, so ties resolve to the lowest index.
          if (scan_cnt > max_q) begin
            max_d  = scan_cnt;
            widx_d = scan_q;
            tie_d  = 1'b0;
          end else if (scan_cnt == max_q && scan_cnt != '0) begin
            tie_d = 1'b1;
          end
          if (scan_q == IDX_W'(NUM_CAND - 1)) state_d = S_RESULT;
          else                                scan_d  = scan_q + IDX_W'(1);
        end
        S_RESULT: begin
          if (cmd_valid && cmd == CMD_OPEN) state_d = S_VOTING;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the voted bitmap and counters are flops, not RAM, because CLEAR and rst must zero them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
      total_q <= '0;
      voted_q <= '0;
      ack_q   <= 1'b0;
      rej_q   <= 1'b0;
      code_q  <= 2'b00;
      scan_q  <= '0;
      widx_q  <= '0;
      max_q   <= '0;
      tie_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      voted_q <= voted_d;
      ack_q   <= ack_d;
      rej_q   <= rej_d;
      code_q  <= code_d;
      scan_q  <= scan_d;
      widx_q  <= widx_d;
      max_q   <= max_d;
      tie_q   <= tie_d;
      rd_q    <= rd_d;
    end
  end

  assign vote_ready = (state_q == S_VOTING);
  assign vote_ack   = ack_q;
  assign vote_rej   = rej_q;
  assign rej_code   = code_q;
  assign state      = state_q;
  assign total      = total_q;
  assign rd_count   = rd_q;
  // An all-zero tally leaves max at zero, which suppresses the winner.
  assign winner     = (state_q == S_RESULT && max_q != '0) ? (NUM_CAND'(1) << widx_q) : '0;
  assign tie        = (state_q == S_RESULT) && tie_q;

endmodule

// File: tb/tb_vote_tally_engine.sv
// Directed bench for vote_tally_engine; a second instance with CNT_W=2 shares the
// stimulus to exercise counter saturation.
module tb_vote_tally_engine;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] OPEN  = 2'b01;
  localparam logic [1:0] CLOSE = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic        vote_valid = 1'b0;
  logic [3:0]  cand_sel = '0;
  logic [3:0]  voter_id = '0;
  logic [3:0]  rd_idx = '0;

  logic        vote_ready, vote_ack, vote_rej, tie;
  logic [1:0]  rej_code, state;
  logic [3:0]  winner;
  logic [11:0] total;
  logic [7:0]  rd_count;

  logic        s_ready, s_ack, s_rej, s_tie;
  logic [1:0]  s_code, s_state;
  logic [3:0]  s_winner;
  logic [11:0] s_total;
  logic [1:0]  s_rd_count;

  int total_n = 0;
  int bad_n   = 0;
  int n;

  vote_tally_engine dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
    .vote_valid(vote_valid), .vote_ready(vote_ready), .cand_sel(cand_sel),
    .voter_id(voter_id), .vote_ack(vote_ack), .vote_rej(vote_rej),
    .rej_code(rej_code), .state(state), .winner(winner), .tie(tie),
    .total(total), .rd_idx(rd_idx), .rd_count(rd_count)
  );

  vote_tally_engine #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
    .vote_valid(vote_valid), .vote_ready(s_ready), .cand_sel(cand_sel),
    .voter_id(voter_id), .vote_ack(s_ack), .vote_rej(s_rej),
    .rej_code(s_code), .state(s_state), .winner(s_winner), .tie(s_tie),
    .total(s_total), .rd_idx(rd_idx), .rd_count(s_rd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp)
    else begin
      bad_n++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic command(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    step();
    cmd_valid = 1'b0;
    cmd       = NONE;
  endtask

  // One-cycle ballot, optionally alongside a command; response is visible on return.
  task automatic vote(input logic [3:0] id, input logic [3:0] sel, input logic [1:0] c);
    vote_valid = 1'b1;
    voter_id   = id;
    cand_sel   = sel;
    cmd_valid  = (c != NONE);
    cmd        = c;
    step();
    vote_valid = 1'b0;
    cmd_valid  = 1'b0;
    cmd        = NONE;
  endtask

  task automatic wait_result(output int cycles);
    cycles = 0;
    while (state != 2'b11 && cycles < 20) begin
      step();
      cycles++;
    end
    if (state != 2'b11) check("result_timeout", 32'(state), 32'h3);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",   32'(state), 32'h0);
    check("rst_total",   32'(total), 32'h0);
    check("rst_ack",     32'(vote_ack), 32'h0);
    check("rst_rdcount", 32'(rd_count), 32'h0);
    check("rst_ready",   32'(vote_ready), 32'h0);
    rst = 1'b0;
    step();

    // Unlisted command in IDLE is ignored
    command(CLOSE);
    check("idle_ignore_close", 32'(state), 32'h0);

    // Basic session: c2 wins with two votes
    command(OPEN);
    check("open_state", 32'(state), 32'h1);
    check("open_ready", 32'(vote_ready), 32'h1);
    command(OPEN);
    check("voting_ignore_open", 32'(state), 32'h1);
    vote(4'd1, 4'b0001, NONE);
    check("a_ack1", {vote_ack, vote_rej}, 32'h2);
    vote(4'd2, 4'b0100, NONE);
    check("a_ack2", {vote_ack, vote_rej}, 32'h2);
    vote(4'd3, 4'b0100, NONE);
    check("a_ack3", {vote_ack, vote_rej}, 32'h2);
    check("a_total", 32'(total), 32'd3);
    step();
    check("a_ack_pulse_drop", {vote_ack, vote_rej}, 32'h0);
    command(CLOSE);
    check("a_tally_state", 32'(state), 32'h2);
    check("a_tally_winner0", 32'(winner), 32'h0);
    wait_result(n);
    check("a_tally_cycles", 32'(n), 32'd4);
    check("a_winner", 32'(winner), 32'b0100);
    check("a_tie", 32'(tie), 32'h0);

    // Count readback in RESULT
    rd_idx = 4'd2;
    step();
    check("rd_c2", 32'(rd_count), 32'd2);
    rd_idx = 4'd9;
    step();
    check("rd_oob", 32'(rd_count), 32'd0);
    rd_idx = 4'd0;
    step();
    check("rd_c0", 32'(rd_count), 32'd1);
    command(CLEAR);
    check("a_clear_state", 32'(state), 32'h0);
    check("a_clear_total", 32'(total), 32'h0);
    step();
    check("a_clear_rd", 32'(rd_count), 32'd0);

    // Duplicate voter then non-one-hot selection
    command(OPEN);
    vote(4'd1, 4'b0010, NONE);
    check("b_ack", {vote_ack, vote_rej, rej_code}, 32'b1000);
    vote(4'd1, 4'b0010, NONE);
    check("b_dup", {vote_ack, vote_rej, rej_code}, 32'b0110);
    vote(4'd1, 4'b0011, NONE);
    check("b_multi", {vote_ack, vote_rej, rej_code}, 32'b0101);
    vote(4'd5, 4'b0000, NONE);
    check("b_zero", {vote_ack, vote_rej, rej_code}, 32'b0101);
    check("b_total", 32'(total), 32'd1);
    command(CLEAR);

    // Tie resolves to the lowest index, then voting resumes from RESULT
    command(OPEN);
    vote(4'd0, 4'b0010, NONE);
    vote(4'd1, 4'b1000, NONE);
    command(CLOSE);
    wait_result(n);
    check("c_tie_winner", 32'(winner), 32'b0010);
    check("c_tie_flag", 32'(tie), 32'h1);
    command(OPEN);
    check("c_resume_state", 32'(state), 32'h1);
    check("c_resume_winner0", {winner, tie}, 32'h0);
    vote(4'd2, 4'b1000, NONE);
    check("c_resume_ack", 32'(vote_ack), 32'h1);
    check("c_resume_total", 32'(total), 32'd3);
    command(CLOSE);
    wait_result(n);
    check("c_resume_winner", 32'(winner), 32'b1000);
    check("c_resume_tie", 32'(tie), 32'h0);
    command(CLEAR);
    command(OPEN);
    command(CLOSE);
    wait_result(n);
    check("c_empty_winner", 32'(winner), 32'h0);
    check("c_empty_tie", 32'(tie), 32'h0);
    command(CLEAR);

    // Saturation on the 2-bit instance; the 8-bit instance keeps accepting
    command(OPEN);
    vote(4'd4, 4'b0001, NONE);
    check("d_sat_ack1", {s_ack, s_rej}, 32'h2);
    vote(4'd5, 4'b0001, NONE);
    check("d_sat_ack2", {s_ack, s_rej}, 32'h2);
    vote(4'd6, 4'b0001, NONE);
    check("d_sat_ack3", {s_ack, s_rej}, 32'h2);
    vote(4'd7, 4'b0001, NONE);
    check("d_sat_rej4", {s_ack, s_rej, s_code}, 32'b0111);
    check("d_wide_ack4", {vote_ack, vote_rej}, 32'h2);
    check("d_sat_total", 32'(s_total), 32'd3);
    rd_idx = 4'd0;
    step();
    check("d_sat_count", 32'(s_rd_count), 32'd3);
    check("d_wide_count", 32'(rd_count), 32'd4);

    // Ballot coincident with CLOSE is counted
    vote(4'd8, 4'b0001, CLOSE);
    check("d_close_ack", {vote_ack, vote_rej}, 32'h2);
    check("d_close_state", 32'(state), 32'h2);
    check("d_close_total", 32'(total), 32'd5);
    wait_result(n);
    check("d_close_winner", 32'(winner), 32'b0001);
    command(CLEAR);

    // CLEAR coincident with a ballot wins
    command(OPEN);
    vote(4'd3, 4'b0100, CLEAR);
    check("e_clear_resp", {vote_ack, vote_rej}, 32'h0);
    check("e_clear_state", 32'(state), 32'h0);
    check("e_clear_total", 32'(total), 32'h0);
    step();
    check("e_clear_resp2", {vote_ack, vote_rej}, 32'h0);

    // Reset mid-TALLY
    command(OPEN);
    vote(4'd1, 4'b0001, NONE);
    command(CLOSE);
    step();
    rst = 1'b1;
    #1;
    check("e_rst_state", 32'(state), 32'h0);
    check("e_rst_total", 32'(total), 32'h0);
    check("e_rst_outs", {vote_ack, vote_rej, rej_code, winner, tie}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    step();
    check("e_rst_after", {state, vote_ack, vote_rej}, 32'h0);

    // Reset mid-handshake: ballot presented, reset covers the edge
    command(OPEN);
    vote_valid = 1'b1;
    voter_id   = 4'd2;
    cand_sel   = 4'b0001;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    vote_valid = 1'b0;
    rst = 1'b0;
    step();
    check("e_hs_rst", {state, vote_ack, vote_rej, total}, 32'h0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
